// File: rtl/pwm_capture_if.sv
// Register bus for pwm_capture: word-addressed CTRL/STATUS/PERIOD/HIGH
// access with registered read data, plus the level interrupt.
interface pwm_capture_if;
  logic [1:0]  addr;
  logic [31:0] wrdata;
  logic        write;
  logic [31:0] rddata;
  logic        irq;

  modport master (
    output addr, wrdata, write,
    input  rddata, irq
  );

  modport slave (
    input  addr, wrdata, write,
    output rddata, irq
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronises pwm_in, detects edges and measures the period
// (rise to rise) and high time (rise to fall) in clk cycles. Results are
// exposed through a small register file with a level interrupt.
module pwm_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;
  logic                   synced, rise, fall;

  logic        ctrl_en, ctrl_irq_en;
  logic        valid, ovf;
  logic [31:0] period_r, high_r;
  logic [31:0] cnt, hi_latch;

  logic wr_ctrl, wr_stat, en_nxt, cnt_max;
  logic cnt_clr, cnt_one, cnt_inc, hi_clr, hi_ld, capture, ovf_set;
  logic unused_wr;

  // A rise with no fall since the previous rise means 100% duty. hi_latch
  // is cleared on every rise and a fall latches a count of at least 1, so
  // zero marks "no fall seen".
  function automatic logic [31:0] high_value(input logic [31:0] hi,
                                             input logic [31:0] per);
    return (hi == '0) ? per : hi;
  endfunction

  assign synced    = sync_p[SYNC_STAGES-1];
  assign rise      = synced & ~prev_p;
  assign fall      = ~synced & prev_p;
  assign wr_ctrl   = bus.write && (bus.addr == 2'd0);
  assign wr_stat   = bus.write && (bus.addr == 2'd1);
  assign en_nxt    = wr_ctrl ? bus.wrdata[0] : ctrl_en;
  assign cnt_max   = (cnt == 32'hFFFF_FFFF);
  assign unused_wr = ^bus.wrdata[31:2];

  // Synchroniser chain followed by the edge-detect flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p <= '0;
      prev_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], pwm_in};
      prev_p <= synced;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state; clearing en returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_nxt) state_nxt = ARM;
      ARM:     if (!en_nxt) state_nxt = IDLE;
               else if (rise) state_nxt = MEAS;
      MEAS:    if (!en_nxt) state_nxt = IDLE;
               else if (cnt_max) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: counter/latch control and capture/overflow strobes
  always_comb begin
    cnt_clr = 1'b0;
    cnt_one = 1'b0;
    cnt_inc = 1'b0;
    hi_clr  = 1'b0;
    hi_ld   = 1'b0;
    capture = 1'b0;
    ovf_set = 1'b0;
    case (state)
      ARM: begin
        if (en_nxt && rise) cnt_one = 1'b1;
        else                cnt_clr = 1'b1;
        hi_clr = 1'b1;
      end
      MEAS: begin
        if (!en_nxt) begin
          cnt_clr = 1'b1;
          hi_clr  = 1'b1;
        end else if (cnt_max) begin
          ovf_set = 1'b1;
          cnt_clr = 1'b1;
          hi_clr  = 1'b1;
        end else if (rise) begin
          capture = 1'b1;
          cnt_one = 1'b1;
          hi_clr  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          hi_ld   = fall;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        hi_clr  = 1'b1;
      end
    endcase
  end

  // Cycle counter and high-time latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      hi_latch <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_one) cnt <= 32'd1;
      else if (cnt_inc) cnt <= cnt + 32'd1;
      if (hi_clr)       hi_latch <= '0;
      else if (hi_ld)   hi_latch <= cnt;
    end
  end

  // Captured PERIOD/HIGH; a newer capture simply overwrites
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_r <= '0;
      high_r   <= '0;
    end else if (capture) begin
      period_r <= cnt;
      high_r   <= high_value(hi_latch, cnt);
    end
  end

  // CTRL and STATUS; a same-cycle set beats a write-1-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      valid       <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= bus.wrdata[0];
        ctrl_irq_en <= bus.wrdata[1];
      end
      valid <= capture | (valid & ~(wr_stat & bus.wrdata[0]));
      ovf   <= ovf_set | (ovf & ~(wr_stat & bus.wrdata[1]));
    end
  end

  // Registered read port; reflects register contents before any same-cycle write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rddata <= '0;
    end else begin
      case (bus.addr)
        2'd0:    bus.rddata <= {30'd0, ctrl_irq_en, ctrl_en};
        2'd1:    bus.rddata <= {30'd0, ovf, valid};
        2'd2:    bus.rddata <= period_r;
        default: bus.rddata <= high_r;
      endcase
    end
  end

  assign bus.irq = ctrl_irq_en & valid;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter SYNC_STAGES, 2, number of synchroniser flops on pwm_in, legal range 2..4.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted while 0, released synchronously to clk.
REQ-004 addr  input  2  word index of register (0 CTRL, 1 STATUS, 2 PERIOD, 3 HIGH).
REQ-005 wrdata  input  32  write data.
REQ-006 write  input  1  write strobe, one cycle per write.
REQ-007 rddata  output  32  registered read data of register selected by addr.
REQ-008 pwm_in  input  1  asynchronous PWM signal to be measured.
REQ-009 irq  output  1  level interrupt, high while a capture is pending and enabled.

Function
REQ-010 CTRL (RW): bit0 en, bit1 irq_en; other bits read 0.
REQ-011 STATUS: bit0 valid, bit1 ovf; writing 1 to a bit clears it, writing 0 has no effect; other bits read 0.
REQ-012 PERIOD, HIGH are read-only; writes to addr 2/3 are ignored.
REQ-013 rddata shall equal the register at addr sampled one cycle earlier (1-cycle read latency); a write and a read to the same address in the same cycle return the pre-write value.
REQ-014 pwm_in passes through SYNC_STAGES flops, then one further flop; rise = synced & ~prev, fall = ~synced & prev.
REQ-015 States: IDLE, ARM, MEAS.
REQ-016 IDLE: counter held at 0; en=1 -> ARM.
REQ-017 ARM: wait for first rise (partial period discarded); on rise: cnt <= 1 -> MEAS.
REQ-018 MEAS: each cycle cnt <= cnt+1; on fall: hi_latch <= cnt; on rise: PERIOD <= cnt, HIGH <= hi_latch, valid <= 1, cnt <= 1, stay MEAS.
REQ-019 PERIOD thus equals clk cycles between consecutive rising edges, HIGH equals cycles from rise to fall.
REQ-020 A rise in MEAS with no fall since the previous rise shall not occur for valid edges; if it does, HIGH <= PERIOD value being captured (100% duty).
REQ-021 Overflow: if cnt = 32'hFFFF_FFFF in MEAS or ARM-with-counting, set ovf, do not update PERIOD/HIGH, -> ARM.
REQ-022 en written 0 in any state: -> IDLE next cycle, cnt and hi_latch cleared, PERIOD/HIGH/STATUS retained.
REQ-023 Simultaneous capture and write-1-clear of valid: capture wins, valid stays 1; same rule for ovf.
REQ-024 Re-capture while valid=1: PERIOD/HIGH overwritten, valid stays 1 (latest wins, no ovf).
REQ-025 irq = irq_en & valid, combinational from registers, glitch-free.
REQ-026 Edge-detect latency from pwm_in transition to rise/fall: SYNC_STAGES+1 cycles; measured values unaffected.

Reset
REQ-027 While rst=0: CTRL, STATUS, PERIOD, HIGH, cnt, hi_latch, synchroniser flops = 0; state IDLE; rddata = 0; irq = 0.
REQ-028 Reset asserted mid-measurement shall abort immediately; after release block stays IDLE until en written 1.

Verification
REQ-029 Write CTRL=1, drive pwm_in period 10 clk, high 3 clk -> after second rise detected, PERIOD=10, HIGH=3, STATUS=1, irq=0.
REQ-030 CTRL=3, same stimulus -> irq=1; write STATUS=1 -> irq=0 next cycle; next period re-asserts irq.
REQ-031 Write STATUS=1 in exact cycle of a capture -> valid reads 1 afterwards.
REQ-032 pwm_in held low after one rise with cnt preloaded by force near 32'hFFFF_FFF0 -> ovf=1, PERIOD/HIGH unchanged, state ARM.
REQ-033 Write CTRL=0 mid-period, then CTRL=1 -> first partial period discarded, next full period measured correctly.
REQ-034 Assert rst=0 mid-measurement -> all registers read 0, irq=0; no capture until CTRL re-enabled.
